// File: rtl/servo_pulse_decoder_if.sv
// rtl/servo_pulse_decoder_if.sv - pulse line and decoded result bundle for servo_pulse_decoder
//
// Purpose: groups the raw PWM input and the decoded outputs of the servo
// pulse decoder so the block and its user share one port.
// Signals:
//   PulseIn   - raw asynchronous PWM line
//   Width     - last accepted pulse width in cycles
//   Direction - 0 forward, 1 neutral, 2 reverse
//   Valid     - one-cycle strobe on a new accepted pulse
//   Error     - one-cycle strobe on a rejected pulse
//   Timeout   - level, high while the signal is lost
// Modports: slave = decoder side, master = source/observer side.

interface servo_pulse_decoder_if;
    logic        PulseIn;
    logic [20:0] Width;
    logic [1:0]  Direction;
    logic        Valid;
    logic        Error;
    logic        Timeout;

    modport slave (
        input  PulseIn,
        output Width,
        output Direction,
        output Valid,
        output Error,
        output Timeout
    );

    modport master (
        output PulseIn,
        input  Width,
        input  Direction,
        input  Valid,
        input  Error,
        input  Timeout
    );
endinterface

// File: rtl/servo_pulse_decoder.sv
// rtl/servo_pulse_decoder.sv - measures RC PWM pulses and decodes them to a direction code
//
// Purpose: synchronizes the PWM line, measures each high pulse in clock
// cycles, accepts widths in [MIN_WIDTH, MAX_WIDTH], decodes the accepted
// width into forward/neutral/reverse and tracks loss of signal.
// Ports:
//   CLK  - system clock
//   RST  - synchronous active-high reset
//   bus  - servo_pulse_decoder_if.slave (PulseIn in; Width, Direction,
//          Valid, Error, Timeout out)

module servo_pulse_decoder #(
    parameter int CLK_RATE      = 100000000,
    parameter int MIN_WIDTH     = CLK_RATE / 1250,
    parameter int MAX_WIDTH     = CLK_RATE * 11 / 5000,
    parameter int NEUTRAL       = CLK_RATE * 3 / 2000,
    parameter int DEADBAND      = CLK_RATE / 10000,
    parameter int FRAME_TIMEOUT = CLK_RATE / 40
) (
    input  logic                  CLK,
    input  logic                  RST,
    servo_pulse_decoder_if.slave  bus
);

    localparam logic [20:0] L_MIN     = 21'(MIN_WIDTH);
    localparam logic [20:0] L_MAX     = 21'(MAX_WIDTH);
    localparam logic [20:0] L_NEUTRAL = 21'(NEUTRAL);
    localparam logic [20:0] L_BAND_LO = 21'(NEUTRAL - DEADBAND);
    localparam logic [20:0] L_BAND_HI = 21'(NEUTRAL + DEADBAND);
    localparam logic [21:0] L_FT      = 22'(FRAME_TIMEOUT);

    typedef enum logic [1:0] {
        ST_WAIT_LOW = 2'd0,
        ST_IDLE     = 2'd1,
        ST_HIGH     = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;

    logic        r_sync1;
    logic        r_s;
    logic        r_s_d;
    logic        r_s_q;
    logic        r_rise;

    logic [20:0] r_hcnt;
    logic [20:0] w_hcnt_nxt;
    logic        w_accept;
    logic        w_reject;
    logic [1:0]  w_dir_new;

    logic [20:0] r_width;
    logic [1:0]  r_dir;
    logic        r_valid;
    logic        r_error;
    logic [21:0] r_tcnt;

    // Sync chain resets high so that a line already high at reset is never
    // seen as a fresh rising edge; WAIT_LOW then waits for a real low.
    // r_s_q is s aligned with the registered rise flag, so the FSM sees the
    // level and its edge on the same cycle.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_sync1 <= 1'b1;
            r_s     <= 1'b1;
            r_s_d   <= 1'b1;
            r_s_q   <= 1'b1;
            r_rise  <= 1'b0;
        end else begin
            r_sync1 <= bus.PulseIn;
            r_s     <= r_sync1;
            r_s_d   <= r_s;
            r_s_q   <= r_s;
            r_rise  <= r_s & ~r_s_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= ST_WAIT_LOW;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // In HIGH, a low r_s_q is exactly the falling edge because r_s_q was
    // high on the previous cycle.
    always_comb begin
        w_state_nxt = r_state;
        w_hcnt_nxt  = r_hcnt;
        w_accept    = 1'b0;
        w_reject    = 1'b0;
        case (r_state)
            ST_WAIT_LOW: begin
                if (!r_s_q) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (r_rise) begin
                    w_hcnt_nxt  = 21'd1;
                    w_state_nxt = ST_HIGH;
                end
            end
            ST_HIGH: begin
                if (r_s_q) begin
                    if (r_hcnt >= L_MAX) begin
                        w_reject    = 1'b1;
                        w_state_nxt = ST_WAIT_LOW;
                    end else begin
                        w_hcnt_nxt = r_hcnt + 21'd1;
                    end
                end else begin
                    if ((r_hcnt >= L_MIN) && (r_hcnt <= L_MAX)) begin
                        w_accept = 1'b1;
                    end else begin
                        w_reject = 1'b1;
                    end
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_WAIT_LOW;
            end
        endcase
    end

    always_comb begin
        w_dir_new = 2'd1;
        if (r_hcnt < L_BAND_LO) begin
            w_dir_new = 2'd0;
        end else if (r_hcnt > L_BAND_HI) begin
            w_dir_new = 2'd2;
        end
    end

    // An accepted pulse wins over the timeout reaching its limit on the
    // same cycle, since the accept branch is taken first.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_hcnt  <= 21'd0;
            r_width <= L_NEUTRAL;
            r_dir   <= 2'd1;
            r_valid <= 1'b0;
            r_error <= 1'b0;
            r_tcnt  <= L_FT;
        end else begin
            r_hcnt  <= w_hcnt_nxt;
            r_valid <= w_accept;
            r_error <= w_reject;
            if (w_accept) begin
                r_width <= r_hcnt;
                r_dir   <= w_dir_new;
                r_tcnt  <= 22'd0;
            end else if (r_tcnt != L_FT) begin
                r_tcnt <= r_tcnt + 22'd1;
                if ((r_tcnt + 22'd1) == L_FT) begin
                    r_width <= L_NEUTRAL;
                    r_dir   <= 2'd1;
                end
            end
        end
    end

    assign bus.Width     = r_width;
    assign bus.Direction = r_dir;
    assign bus.Valid     = r_valid;
    assign bus.Error     = r_error;
    assign bus.Timeout   = (r_tcnt == L_FT);

endmodule

// File: tb/tb_servo_pulse_decoder.sv
// tb/tb_servo_pulse_decoder.sv - scoreboard bench for servo_pulse_decoder

module tb_servo_pulse_decoder;

    localparam int MINW = 80;
    localparam int MAXW = 220;
    localparam int NEUT = 150;
    localparam int DBND = 10;
    localparam int FTO  = 2500;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    int   cyc = 0;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        bit is_err;
        int w;
        int d;
        int cyc;
    } exp_t;

    typedef struct {
        int n;
        int gap;
        bit is_err;
        int w;
        int d;
    } vec_t;

    exp_t sb[$];

    servo_pulse_decoder_if bus();

    servo_pulse_decoder #(
        .CLK_RATE      (100000),
        .MIN_WIDTH     (MINW),
        .MAX_WIDTH     (MAXW),
        .NEUTRAL       (NEUT),
        .DEADBAND      (DBND),
        .FRAME_TIMEOUT (FTO)
    ) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int exp_v);
        n_checks++;
        if (act != exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp_v, cyc);
        end
    endtask

    // Monitor: every strobe must match the oldest pending expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge CLK);
            if (bus.Valid || bus.Error) begin
                chk("valid_error_exclusive", int'(bus.Valid && bus.Error), 0);
                chk("strobe_expected", int'(sb.size() > 0), 1);
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    chk("strobe_kind_error", int'(bus.Error), int'(e.is_err));
                    chk("width", int'(bus.Width), e.w);
                    chk("direction", int'(bus.Direction), e.d);
                    chk("strobe_cycle", cyc, e.cyc);
                    if (!e.is_err) chk("timeout_low_on_valid", int'(bus.Timeout), 0);
                end
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge CLK);
    endtask

    // Raw line is high for exactly n sampling edges; the strobe follows
    // three edges after the first edge that samples it low.
    task automatic pulse(input int n, input bit expect_strobe, input bit is_err,
                         input int w, input int d);
        @(posedge CLK);
        #1 bus.PulseIn = 1'b1;
        repeat (n) @(posedge CLK);
        #1 bus.PulseIn = 1'b0;
        if (expect_strobe) sb.push_back('{is_err, w, d, cyc + 4});
    endtask

    vec_t vecs[13] = '{
        '{150, 1850, 1'b0, 150, 1},
        '{150, 1850, 1'b0, 150, 1},
        '{100,  300, 1'b0, 100, 0},
        '{200,  300, 1'b0, 200, 2},
        '{139,  300, 1'b0, 139, 0},
        '{140,  300, 1'b0, 140, 1},
        '{160,  300, 1'b0, 160, 1},
        '{161,  300, 1'b0, 161, 2},
        '{150,   50, 1'b0, 150, 1},
        '{  5,  300, 1'b1, 150, 1},
        '{ 79,  300, 1'b1, 150, 1},
        '{ 80,  300, 1'b0,  80, 0},
        '{220,  300, 1'b0, 220, 2}
    };

    initial begin
        int vcyc;
        bus.PulseIn = 1'b0;
        RST = 1'b1;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        chk("reset_width", int'(bus.Width), NEUT);
        chk("reset_direction", int'(bus.Direction), 1);
        chk("reset_valid", int'(bus.Valid), 0);
        chk("reset_error", int'(bus.Error), 0);
        chk("reset_timeout", int'(bus.Timeout), 1);
        #1 RST = 1'b0;
        idle(10);

        foreach (vecs[i]) begin
            pulse(vecs[i].n, 1'b1, vecs[i].is_err, vecs[i].w, vecs[i].d);
            idle(vecs[i].gap);
        end

        // Overlong pulse: one Error when hcnt would pass MAXW, nothing at the fall.
        @(posedge CLK);
        #1 bus.PulseIn = 1'b1;
        sb.push_back('{1'b1, 220, 2, cyc + MAXW + 4});
        repeat (300) @(posedge CLK);
        #1 bus.PulseIn = 1'b0;
        idle(300);
        pulse(120, 1'b1, 1'b0, 120, 0);
        idle(300);

        // Loss of signal after a valid pulse.
        pulse(200, 1'b1, 1'b0, 200, 2);
        vcyc = cyc + 4;
        while (cyc < vcyc + FTO - 1) @(negedge CLK);
        chk("timeout_not_yet", int'(bus.Timeout), 0);
        chk("width_before_timeout", int'(bus.Width), 200);
        @(negedge CLK);
        chk("timeout_set", int'(bus.Timeout), 1);
        chk("width_forced_neutral", int'(bus.Width), NEUT);
        chk("direction_forced_neutral", int'(bus.Direction), 1);
        idle(20);

        // Reset in the middle of a pulse; line stays high afterwards.
        @(posedge CLK);
        #1 bus.PulseIn = 1'b1;
        repeat (50) @(posedge CLK);
        #1 RST = 1'b1;
        repeat (3) @(posedge CLK);
        #1 RST = 1'b0;
        @(negedge CLK);
        chk("timeout_after_reset", int'(bus.Timeout), 1);
        repeat (100) @(posedge CLK);
        #1 bus.PulseIn = 1'b0;
        idle(50);
        pulse(150, 1'b1, 1'b0, 150, 1);

        idle(30);
        chk("scoreboard_drained", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
